// File: rtl/video_pattern_gen.sv
// video_pattern_gen: frame-based test-pattern source producing x, y, checker
// and frame-index patterns with per-line and per-frame blanking.
// Optional build macro: VIDEO_PATTERN_GEN_LFSR_EN turns pattern 3 into a
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) seeded at each start of frame.
module video_pattern_gen #(
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 512,
  parameter int unsigned DW           = 16,
  parameter int unsigned HBLANK       = 16,
  parameter int unsigned VBLANK       = 4
) (
  input  logic          i_Sys_clk,
  input  logic          i_Rst,
  input  logic          i_Start,
  input  logic          i_Stop,
  input  logic [7:0]    i_Frame_num,
  input  logic [1:0]    i_Pattern,
  output logic          o_Dout_valid,
  output logic [DW-1:0] o_Dout,
  output logic          o_Sof,
  output logic          o_Eol,
  output logic          o_Eof,
  output logic          o_Busy
);

  localparam int unsigned CMAX_A = (IMAGE_WIDTH > HBLANK) ? IMAGE_WIDTH : HBLANK;
  localparam int unsigned CMAX   = (CMAX_A > VBLANK) ? CMAX_A : VBLANK;
  localparam int unsigned CW     = $clog2(CMAX + 1);
  localparam int unsigned YW     = $clog2(IMAGE_HEIGHT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [YW-1:0] line, line_n;
  logic [7:0]    frame, frame_n;
  logic [7:0]    frame_tgt, frame_tgt_n;
  logic [1:0]    pat, pat_n;
  logic          stop_pend, stop_pend_n;
  logic          act_n;
  logic          sof_d, eol_d, eof_d;
  logic          chk;
  logic [DW-1:0] pat3;
  logic [DW-1:0] pix_d;

  // State register
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state, counter updates and per-pixel flags for the upcoming cycle
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    line_n      = line;
    frame_n     = frame;
    frame_tgt_n = frame_tgt;
    pat_n       = pat;
    stop_pend_n = stop_pend | i_Stop;

    case (state)
      ST_IDLE: begin
        stop_pend_n = 1'b0;
        if (i_Start) begin
          state_n     = ST_ACTIVE;
          cnt_n       = '0;
          line_n      = '0;
          frame_n     = '0;
          frame_tgt_n = i_Frame_num;
          pat_n       = i_Pattern;
          // A stop arriving with the start still yields exactly one frame
          stop_pend_n = i_Stop;
        end
      end
      ST_ACTIVE: begin
        if (cnt == CW'(IMAGE_WIDTH - 1)) begin
          state_n = ST_HBLANK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_HBLANK: begin
        if (cnt == CW'(HBLANK - 1)) begin
          cnt_n = '0;
          if (line == YW'(IMAGE_HEIGHT - 1)) begin
            state_n = ST_VBLANK;
          end else begin
            state_n = ST_ACTIVE;
            line_n  = line + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_VBLANK: begin
        if (cnt == CW'(VBLANK - 1)) begin
          cnt_n  = '0;
          line_n = '0;
          if (stop_pend_n || ((frame_tgt != 8'd0) && ((frame + 8'd1) == frame_tgt))) begin
            state_n     = ST_IDLE;
            stop_pend_n = 1'b0;
          end else begin
            state_n = ST_ACTIVE;
            frame_n = frame + 8'd1;
            pat_n   = i_Pattern;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    act_n = (state_n == ST_ACTIVE);
    sof_d = act_n && (cnt_n == '0) && (line_n == '0);
    eol_d = act_n && (cnt_n == CW'(IMAGE_WIDTH - 1));
    eof_d = eol_d && (line_n == YW'(IMAGE_HEIGHT - 1));
  end

`ifdef VIDEO_PATTERN_GEN_LFSR_EN
  logic [15:0] lfsr, lfsr_n;

  // LFSR value for the upcoming pixel: reseed at start of frame, step per pixel
  always_comb begin
    lfsr_n = lfsr;
    if (sof_d)      lfsr_n = 16'hACE1;
    else if (act_n) lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // LFSR register
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) lfsr <= '0;
    else       lfsr <= lfsr_n;
  end

  assign pat3 = DW'(lfsr_n);
`else
  assign pat3 = DW'(frame_n);
`endif

  // Pixel value for the upcoming cycle from the frame-latched pattern
  always_comb begin
    chk = 1'((32'(cnt_n) ^ 32'(line_n)) >> 3);
    case (pat_n)
      2'd0:    pix_d = DW'(cnt_n);
      2'd1:    pix_d = DW'(line_n);
      2'd2:    pix_d = chk ? {DW{1'b1}} : '0;
      default: pix_d = pat3;
    endcase
  end

  // Position, frame bookkeeping and pending stop
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt       <= '0;
      line      <= '0;
      frame     <= '0;
      frame_tgt <= '0;
      pat       <= '0;
      stop_pend <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      line      <= line_n;
      frame     <= frame_n;
      frame_tgt <= frame_tgt_n;
      pat       <= pat_n;
      stop_pend <= stop_pend_n;
    end
  end

  // Registered video outputs; data holds its last value outside active pixels
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Dout_valid <= 1'b0;
      o_Dout       <= '0;
      o_Sof        <= 1'b0;
      o_Eol        <= 1'b0;
      o_Eof        <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      o_Dout_valid <= act_n;
      o_Sof        <= sof_d;
      o_Eol        <= eol_d;
      o_Eof        <= eof_d;
      o_Busy       <= (state_n != ST_IDLE);
      if (act_n) o_Dout <= pix_d;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed bench for video_pattern_gen (4x2 frame with
// HBLANK=2, VBLANK=3, plus a 16-wide instance for the checker/pattern-3 case).
`timescale 1ns/1ps
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, stop;
  logic [7:0]  frame_num;
  logic [1:0]  pattern;
  logic        valid, sof, eol, eof, busy;
  logic [15:0] dout;

  logic        start16, stop16;
  logic [7:0]  frame_num16;
  logic [1:0]  pattern16;
  logic        valid16, sof16, eol16, eof16, busy16;
  logic [15:0] dout16;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] d;
    logic        s;
    logic        l;
    logic        e;
    int          c;
  } pix_t;

  pix_t        q[$];
  logic [15:0] q16[$];

  video_pattern_gen #(
    .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .DW(16), .HBLANK(2), .VBLANK(3)
  ) dut (
    .i_Sys_clk(clk), .i_Rst(rst), .i_Start(start), .i_Stop(stop),
    .i_Frame_num(frame_num), .i_Pattern(pattern),
    .o_Dout_valid(valid), .o_Dout(dout), .o_Sof(sof), .o_Eol(eol),
    .o_Eof(eof), .o_Busy(busy)
  );

  video_pattern_gen #(
    .IMAGE_WIDTH(16), .IMAGE_HEIGHT(2), .DW(16), .HBLANK(2), .VBLANK(3)
  ) dut16 (
    .i_Sys_clk(clk), .i_Rst(rst), .i_Start(start16), .i_Stop(stop16),
    .i_Frame_num(frame_num16), .i_Pattern(pattern16),
    .o_Dout_valid(valid16), .o_Dout(dout16), .o_Sof(sof16), .o_Eol(eol16),
    .o_Eof(eof16), .o_Busy(busy16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid pixel away from the active edge
  always @(negedge clk) begin
    if (valid)   q.push_back('{d: dout, s: sof, l: eol, e: eof, c: cyc});
    if (valid16) q16.push_back(dout16);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] n, input logic [1:0] p,
                             input logic with_stop, output int s);
    @(posedge clk); #1;
    frame_num = n; pattern = p; start = 1'b1; stop = with_stop;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; s = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin @(negedge clk); k++; end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_idle16(input int budget);
    int k = 0;
    @(negedge clk);
    while (busy16 && k < budget) begin @(negedge clk); k++; end
    check("idle16_timeout", 32'(busy16), 32'd0);
  endtask

  task automatic wait_pix(input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin @(negedge clk); k++; end
    check("pix_timeout", 32'(q.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int fall;
    int eofs;
    start = 0; stop = 0; frame_num = 0; pattern = 0;
    start16 = 0; stop16 = 0; frame_num16 = 0; pattern16 = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dout",  32'(dout),  32'd0);
    check("rst_flags", 32'({sof, eol, eof}), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // One frame of pattern 0; a second start mid-run must be ignored
    q.delete();
    pulse_start(8'd1, 2'd0, 1'b0, s);
    check("t1_busy_hi", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1 frame_num = 8'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(100);
    fall = cyc;
    check("t1_count", 32'(q.size()), 32'd8);
    if (q.size() == 8) begin
      check("t1_latency", 32'(q[0].c), 32'(s));
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t1_dout%0d", i), 32'(q[i].d), 32'(i % 4));
        check($sformatf("t1_eol%0d", i),  32'(q[i].l), 32'((i % 4) == 3));
        check($sformatf("t1_sof%0d", i),  32'(q[i].s), 32'(i == 0));
        check($sformatf("t1_eof%0d", i),  32'(q[i].e), 32'(i == 7));
      end
      check("t1_line_contig", 32'(q[3].c - q[0].c), 32'd3);
      check("t1_hgap",        32'(q[4].c - q[3].c), 32'd3);
      check("t1_busy_fall",   32'(fall - q[7].c),   32'd6);
    end
    check("t1_hold", 32'(dout), 32'd3);
    repeat (5) @(negedge clk);
    check("t1_stay_idle", 32'({busy, valid}), 32'd0);

    // Continuous pattern 1, stop during frame 2
    q.delete();
    pulse_start(8'd0, 2'd1, 1'b0, s);
    wait_pix(10, 200);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_idle(200);
    check("t2_count", 32'(q.size()), 32'd16);
    if (q.size() == 16) begin
      for (int i = 8; i < 16; i++)
        check($sformatf("t2_dout%0d", i), 32'(q[i].d), 32'(i >= 12));
      check("t2_eof", 32'(q[15].e), 32'd1);
      check("t2_sof2", 32'(q[8].s), 32'd1);
    end

    // Pattern change mid-frame takes effect at next frame
    q.delete();
    pulse_start(8'd2, 2'd0, 1'b0, s);
    wait_pix(2, 50);
    @(posedge clk); #1 pattern = 2'd1;
    wait_idle(200);
    check("t3_count", 32'(q.size()), 32'd16);
    if (q.size() == 16) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t3_f1_%0d", i), 32'(q[i].d),     32'(i % 4));
        check($sformatf("t3_f2_%0d", i), 32'(q[i + 8].d), 32'(i >= 4));
      end
    end

    // Pattern 3 over three frames
    q.delete();
    pulse_start(8'd3, 2'd3, 1'b0, s);
    wait_idle(300);
    check("p3_count", 32'(q.size()), 32'd24);
    if (q.size() == 24) begin
`ifdef VIDEO_PATTERN_GEN_LFSR_EN
      check("p3_px0",   32'(q[0].d), 32'h0000ACE1);
      check("p3_px1",   32'(q[1].d), 32'h00005670);
      check("p3_px2",   32'(q[2].d), 32'h0000AB38);
      check("p3_reseed", 32'(q[8].d), 32'h0000ACE1);
`else
      check("p3_f0a", 32'(q[0].d),  32'd0);
      check("p3_f0b", 32'(q[7].d),  32'd0);
      check("p3_f1",  32'(q[8].d),  32'd1);
      check("p3_f2a", 32'(q[16].d), 32'd2);
      check("p3_f2b", 32'(q[23].d), 32'd2);
`endif
    end

    // Start and stop together in IDLE -> exactly one frame
    q.delete();
    pulse_start(8'd0, 2'd0, 1'b1, s);
    wait_idle(200);
    check("t5_count", 32'(q.size()), 32'd8);

    // Reset on the third valid pixel
    q.delete();
    pulse_start(8'd1, 2'd0, 1'b0, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_px3_valid", 32'(valid), 32'd1);
    check("t4_px3_dout",  32'(dout),  32'd2);
    rst = 1'b1;
    #1;
    check("t4_rst_outs", 32'({valid, sof, eol, eof, busy}), 32'd0);
    check("t4_rst_dout", 32'(dout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_no_restart", 32'({busy, valid}), 32'd0);
    check("t4_cap_count", 32'(q.size()), 32'd2);
    eofs = 0;
    foreach (q[i]) if (q[i].e) eofs++;
    check("t4_no_eof", 32'(eofs), 32'd0);
    q.delete();
    pulse_start(8'd1, 2'd0, 1'b0, s);
    wait_idle(100);
    check("t4_count", 32'(q.size()), 32'd8);
    if (q.size() == 8) begin
      check("t4_x0",  32'(q[0].d), 32'd0);
      check("t4_sof", 32'(q[0].s), 32'd1);
      check("t4_x3",  32'(q[3].d), 32'd3);
      check("t4_eof", 32'(q[7].e), 32'd1);
    end

    // 16-wide checkerboard on the second instance
    q16.delete();
    @(posedge clk); #1;
    frame_num16 = 8'd1; pattern16 = 2'd2; start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    wait_idle16(200);
    check("t6_count", 32'(q16.size()), 32'd32);
    if (q16.size() == 32) begin
      for (int i = 0; i < 16; i++)
        check($sformatf("t6_chk%0d", i), 32'(q16[i]), (i < 8) ? 32'h0 : 32'h0000FFFF);
    end

    // Pattern 3 on the wide instance
    q16.delete();
    @(posedge clk); #1;
    frame_num16 = 8'd1; pattern16 = 2'd3; start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    wait_idle16(200);
    check("t6_p3_count", 32'(q16.size()), 32'd32);
    if (q16.size() == 32) begin
`ifdef VIDEO_PATTERN_GEN_LFSR_EN
      check("t6_lfsr0", 32'(q16[0]), 32'h0000ACE1);
      check("t6_lfsr1", 32'(q16[1]), 32'h00005670);
`else
      check("t6_fidx0", 32'(q16[0]),  32'd0);
      check("t6_fidx1", 32'(q16[31]), 32'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
